// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID/EX pipeline logic and the hazard controller: ID-stage decode in,
// forwarding selects and stall/flush controls out.
interface hazard_ctrl_if #(
  parameter int XLEN_REGS = 5,
  parameter int CNT_W     = 16
);
  // ID_valid qualifies every ID_* field in the same cycle; there is no back-pressure
  // signal, the controller samples the ID fields on every rising clock edge.
  logic                 ID_valid;
  logic [XLEN_REGS-1:0] ID_rs1;
  logic [XLEN_REGS-1:0] ID_rs2;
  logic                 ID_use_rs1;
  logic                 ID_use_rs2;
  logic [XLEN_REGS-1:0] ID_rd;
  logic                 ID_reg_write;
  logic                 ID_mem_read;
  logic                 EX_branch_taken;
  logic [1:0]           ForwardAE;
  logic [1:0]           ForwardBE;
  logic                 stall_F;
  logic                 stall_D;
  logic                 flush_D;
  logic                 flush_E;
  logic [CNT_W-1:0]     load_use_cnt;

  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd,
           ID_reg_write, ID_mem_read, EX_branch_taken,
    input  ForwardAE, ForwardBE, stall_F, stall_D, flush_D, flush_E, load_use_cnt
  );

  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd,
           ID_reg_write, ID_mem_read, EX_branch_taken,
    output ForwardAE, ForwardBE, stall_F, stall_D, flush_D, flush_E, load_use_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: shadow EX/MEM/WB slots drive operand-forwarding
// selects; load-use and taken-branch detection drive stall/flush of IF/ID/EX.
module hazard_ctrl #(
  parameter int XLEN_REGS = 5,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          reset_n,
  hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic                 valid;
    logic [XLEN_REGS-1:0] rs1;
    logic [XLEN_REGS-1:0] rs2;
    logic [XLEN_REGS-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
  } ex_slot_t;

  typedef struct packed {
    logic                 valid;
    logic [XLEN_REGS-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
  } mem_slot_t;

  // WB only ever acts as a forwarding source, so it does not keep mem_read.
  typedef struct packed {
    logic                 valid;
    logic [XLEN_REGS-1:0] rd;
    logic                 reg_write;
  } wb_slot_t;

  ex_slot_t         ex_q;
  ex_slot_t         ex_d;
  mem_slot_t        mem_q;
  wb_slot_t         wb_q;
  logic [CNT_W-1:0] cnt_q;

  logic       ex_writing;
  logic       mem_writing;
  logic       wb_writing;
  logic       mem_fwd_ok;
  logic       lu;
  logic       br;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign ex_writing  = ex_q.valid  & ex_q.reg_write  & (ex_q.rd  != '0);
  assign mem_writing = mem_q.valid & mem_q.reg_write & (mem_q.rd != '0);
  assign wb_writing  = wb_q.valid  & wb_q.reg_write  & (wb_q.rd  != '0);
  // A load in MEM only has its address on the ALU bus, so it cannot forward.
  assign mem_fwd_ok  = mem_writing & ~mem_q.mem_read;
  assign br          = hz.EX_branch_taken;

  assign lu = hz.ID_valid & ex_writing & ex_q.mem_read &
              ((hz.ID_use_rs1 & (hz.ID_rs1 == ex_q.rd)) |
               (hz.ID_use_rs2 & (hz.ID_rs2 == ex_q.rd)));

  // Selects depend on registered slots only; MEM is checked first since it is newer.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_q.valid) begin
      if (mem_fwd_ok && (mem_q.rd == ex_q.rs1))     fwd_a = 2'b10;
      else if (wb_writing && (wb_q.rd == ex_q.rs1)) fwd_a = 2'b01;
      if (mem_fwd_ok && (mem_q.rd == ex_q.rs2))     fwd_b = 2'b10;
      else if (wb_writing && (wb_q.rd == ex_q.rs2)) fwd_b = 2'b01;
    end
  end

  always_comb begin
    ex_d = '0;
    if (hz.ID_valid && !lu && !br) begin
      ex_d.valid     = 1'b1;
      ex_d.rs1       = hz.ID_rs1;
      ex_d.rs2       = hz.ID_rs2;
      ex_d.rd        = hz.ID_rd;
      ex_d.reg_write = hz.ID_reg_write;
      ex_d.mem_read  = hz.ID_mem_read;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q            <= ex_d;
      mem_q.valid     <= ex_q.valid;
      mem_q.rd        <= ex_q.rd;
      mem_q.reg_write <= ex_q.reg_write;
      mem_q.mem_read  <= ex_q.mem_read;
      wb_q.valid      <= mem_q.valid;
      wb_q.rd         <= mem_q.rd;
      wb_q.reg_write  <= mem_q.reg_write;
      if (lu && !br && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A taken branch squashes the would-be stalled instruction, so it overrides the stall.
  assign hz.stall_F      = lu & ~br;
  assign hz.stall_D      = lu & ~br;
  assign hz.flush_D      = br;
  assign hz.flush_E      = lu | br;
  assign hz.ForwardAE    = fwd_a;
  assign hz.ForwardBE    = fwd_b;
  assign hz.load_use_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard sequences plus random instruction
// streams compared against an instruction-history reference model.
module tb_hazard_ctrl;
  localparam int XR = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.XLEN_REGS(XR), .CNT_W(CW)) hz ();
  hazard_ctrl #(.XLEN_REGS(XR), .CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .hz(hz));

  typedef struct {
    bit v;
    int rs1;
    int rs2;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  // Model: hist holds the last three instructions that entered EX, oldest first (WB, MEM, EX).
  instr_t hist[$];
  instr_t cur;
  bit     cur_u1, cur_u2, cur_bt;
  int     exp_cnt;
  int     total = 0;
  int     bad = 0;
  int     c0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(input instr_t i);
    return i.v && i.rw && (i.rd != 0);
  endfunction

  function automatic int fwd_of(input int src);
    instr_t ex, mem, wb;
    wb = hist[0]; mem = hist[1]; ex = hist[2];
    if (!ex.v) return 0;
    if (writes(mem) && !mem.mr && mem.rd == src) return 2;
    if (writes(wb) && wb.rd == src) return 1;
    return 0;
  endfunction

  function automatic bit lu_of();
    instr_t ex;
    ex = hist[2];
    return cur.v && writes(ex) && ex.mr &&
           ((cur_u1 && cur.rs1 == ex.rd) || (cur_u2 && cur.rs2 == ex.rd));
  endfunction

  task automatic model_reset();
    instr_t b;
    b = '{0, 0, 0, 0, 0, 0};
    hist.delete();
    repeat (3) hist.push_back(b);
    exp_cnt = 0;
  endtask

  task automatic model_advance();
    instr_t e;
    bit l;
    l = lu_of();
    e = cur;
    if (l || cur_bt || !cur.v) e = '{0, 0, 0, 0, 0, 0};
    void'(hist.pop_front());
    hist.push_back(e);
    if (l && !cur_bt && exp_cnt < (1 << CW) - 1) exp_cnt++;
  endtask

  task automatic apply(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit bt);
    cur = '{v, rs1, rs2, rd, rw, mr};
    cur_u1 = u1; cur_u2 = u2; cur_bt = bt;
    hz.ID_valid = v;
    hz.ID_rs1 = XR'(rs1);
    hz.ID_rs2 = XR'(rs2);
    hz.ID_use_rs1 = u1;
    hz.ID_use_rs2 = u2;
    hz.ID_rd = XR'(rd);
    hz.ID_reg_write = rw;
    hz.ID_mem_read = mr;
    hz.EX_branch_taken = bt;
  endtask

  task automatic check_model();
    bit l;
    l = lu_of();
    chk("fwd_a", int'(hz.ForwardAE), fwd_of(cur.v ? hist[2].rs1 : hist[2].rs1));
    chk("fwd_b", int'(hz.ForwardBE), fwd_of(hist[2].rs2));
    chk("stall_f", int'(hz.stall_F), int'(l && !cur_bt));
    chk("stall_d", int'(hz.stall_D), int'(l && !cur_bt));
    chk("flush_d", int'(hz.flush_D), int'(cur_bt));
    chk("flush_e", int'(hz.flush_E), int'(l || cur_bt));
    chk("lu_cnt", int'(hz.load_use_cnt), exp_cnt);
  endtask

  // One pipeline cycle: the edge consumes the previous ID inputs, then new ones are driven.
  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit bt);
    @(posedge clk);
    model_advance();
    @(negedge clk);
    apply(v, rs1, rs2, u1, u2, rd, rw, mr, bt);
    #1;
    check_model();
  endtask

  task automatic nop();                                drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input int rd, input int a, input int b); drive(1, a, b, 1, 1, rd, 1, 0, 0); endtask
  task automatic ld(input int rd, input int a);        drive(1, a, 0, 1, 0, rd, 1, 1, 0); endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_fa"}, int'(hz.ForwardAE), 0);
    chk({tag, "_fb"}, int'(hz.ForwardBE), 0);
    chk({tag, "_st"}, int'({hz.stall_F, hz.stall_D, hz.flush_D, hz.flush_E}), 0);
    chk({tag, "_cnt"}, int'(hz.load_use_cnt), 0);
  endtask

  task automatic leave_reset();
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    leave_reset();

    // EX/MEM forward: add x5 ; sub x6,x5,x1
    alu(5, 1, 2); alu(6, 5, 1); nop();
    chk("exmem_fa", int'(hz.ForwardAE), 2);
    chk("exmem_fb", int'(hz.ForwardBE), 0);
    chk("exmem_stall", int'(hz.stall_F), 0);

    // WB forward: add x5 ; nop ; or x7,x1,x5
    alu(5, 1, 2); nop(); alu(7, 1, 5); nop();
    chk("wb_fb", int'(hz.ForwardBE), 1);

    // MEM beats WB: add x5 ; add x5 ; xor x8,x5,x5
    alu(5, 1, 2); alu(5, 3, 4); alu(8, 5, 5); nop();
    chk("prio_fa", int'(hz.ForwardAE), 2);
    chk("prio_fb", int'(hz.ForwardBE), 2);

    // x0 never forwards
    alu(0, 1, 2); alu(9, 0, 1); nop();
    chk("x0_fa", int'(hz.ForwardAE), 0);

    // Matching but unused rs2 behind a load: no stall
    ld(3, 1); drive(1, 1, 3, 1, 0, 4, 1, 0, 0);
    chk("unused_stall", int'(hz.stall_F), 0);
    nop(); nop();

    // Load-use: lw x3 ; add x4,x3,x2 held in ID for the stall cycle
    c0 = exp_cnt;
    ld(3, 1); alu(4, 3, 2);
    chk("lu_stall_f", int'(hz.stall_F), 1);
    chk("lu_stall_d", int'(hz.stall_D), 1);
    chk("lu_flush_e", int'(hz.flush_E), 1);
    chk("lu_cnt_before", int'(hz.load_use_cnt), c0);
    alu(4, 3, 2);
    chk("lu_second_stall", int'(hz.stall_F), 0);
    chk("lu_cnt_after", int'(hz.load_use_cnt), c0 + 1);
    nop();
    chk("lu_fa_wb", int'(hz.ForwardAE), 1);
    nop(); nop();

    // Branch in the same cycle as a load-use match
    c0 = exp_cnt;
    ld(3, 1); drive(1, 3, 2, 1, 1, 4, 1, 0, 1);
    chk("br_flush_d", int'(hz.flush_D), 1);
    chk("br_flush_e", int'(hz.flush_E), 1);
    chk("br_stall", int'({hz.stall_F, hz.stall_D}), 0);
    nop();
    chk("br_cnt", int'(hz.load_use_cnt), c0);

    // Async reset in the middle of a load-use stall
    ld(3, 1); alu(4, 3, 2);
    chk("mid_stall", int'(hz.stall_F), 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    leave_reset();

    // Random streams over a small register range to provoke frequent hazards
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
